// File: rtl/cla_seq_arbiter.sv
// ============================================================================
// cla_seq_arbiter : round-robin arbiter feeding a nibble-serial adder built on
//                   an external 4-bit carry-lookahead slice.
// Optional: CLA_SEQ_OVF_FLAG_EN adds the rsp_ovf two's-complement flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_id,
    output logic [3:0]             slc_a,
    output logic [3:0]             slc_b,
    output logic                   slc_cin,
    input  logic [3:0]             slc_s,
    input  logic                   slc_cout
`ifdef CLA_SEQ_OVF_FLAG_EN
    ,
    output logic                   rsp_ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cin_q, cin_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic            gnt0, gnt1;
    logic            last_nibble;

    // last_q is the requester served most recently; on a tie the other one wins.
    assign gnt0 = req0_valid && (!req1_valid || last_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_q);

    assign last_nibble = (state_q == S_ADD) && (idx_q == IDX_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        cin_d      = cin_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        id_d       = id_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        slc_a      = 4'h0;
        slc_b      = 4'h0;
        slc_cin    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a   : req0_a;
                    b_d     = gnt1 ? req1_b   : req0_b;
                    cin_d   = gnt1 ? req1_cin : req0_cin;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                slc_a   = a_q[{idx_q, 2'b00} +: 4];
                slc_b   = b_q[{idx_q, 2'b00} +: 4];
                slc_cin = (idx_q == '0) ? cin_q : carry_q;
                sum_d[{idx_q, 2'b00} +: 4] = slc_s;
                carry_d = slc_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    cout_d  = slc_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

`ifdef CLA_SEQ_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // The top sum bit is produced by the slice during the final nibble cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (last_nibble) begin
            ovf_d = (a_q[W-1] == b_q[W-1]) && (slc_s[3] != a_q[W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_ovf = ovf_q;
`else
    logic unused_last_nibble;
    assign unused_last_nibble = last_nibble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_arbiter.sv
// ============================================================================
// tb_cla_seq_arbiter : directed scoreboard bench for cla_seq_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_seq_arbiter;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_cin = 1'b0, req1_cin = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout, rsp_id;
    logic [3:0]    slc_a, slc_b, slc_s;
    logic          slc_cin, slc_cout;
`ifdef CLA_SEQ_OVF_FLAG_EN
    logic          rsp_ovf;
`endif

    // Behavioural 4-bit slice.
    assign {slc_cout, slc_s} = {1'b0, slc_a} + {1'b0, slc_b} + {4'h0, slc_cin};

    cla_seq_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .slc_a      (slc_a),
        .slc_b      (slc_b),
        .slc_cin    (slc_cin),
        .slc_s      (slc_s),
        .slc_cout   (slc_cout)
`ifdef CLA_SEQ_OVF_FLAG_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t       r;
        logic [W:0] s;
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = s[W-1:0];
        r.cout = s[W];
        r.id   = id;
        r.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic compare_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},  rsp_sum,  e.sum);
            check({tag, "_cout"}, rsp_cout, e.cout);
            check({tag, "_id"},   rsp_id,   e.id);
`ifdef CLA_SEQ_OVF_FLAG_EN
            check({tag, "_ovf"},  rsp_ovf,  e.ovf);
`endif
        end
    endtask

    // Called right after a negedge; returns at the negedge after the acceptance edge.
    task automatic accept(input string tag, input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_grant"}, (n < 10), 1);
        check({tag, "_loser_ready"}, (id ? req0_ready : req1_ready), 0);
        sb.push_back(model(id, a, b, cin));
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'b1;
        end else begin
            req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'b1;
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, NIBBLES + 1);
        compare_rsp(tag);
        check({tag, "_slc_done"}, {slc_a, slc_b, slc_cin}, 0);
        @(negedge clk);
        check({tag, "_to_idle"}, rsp_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] held_sum;
        logic         stable;
        logic         saw_valid;
        logic         grants[4];
        int           ng, nr, cyc;
        exp_t         dropped;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum",   rsp_sum,   0);
        check("rst_cout",  rsp_cout,  0);
        check("rst_id",    rsp_id,    0);
        check("rst_slc",   {slc_a, slc_b, slc_cin}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);

        // Basic operations
        accept("op1234", 1'b0, 16'h1234, 16'h4321, 1'b0);
        wait_rsp("op1234");
        accept("opFFFF", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        wait_rsp("opFFFF");
        accept("op7FFF", 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        wait_rsp("op7FFF");
        accept("op0F0F", 1'b0, 16'h0F0F, 16'h00F1, 1'b1);
        check("op0F0F_slc_cin0", slc_cin, 1);
        wait_rsp("op0F0F");
        accept("op8000", 1'b0, 16'h8000, 16'h8000, 1'b1);
        wait_rsp("op8000");

        // Backpressure in DONE
        rsp_ready = 1'b0;
        accept("hold", 1'b1, 16'hA5A5, 16'h1111, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_reached_done", rsp_valid, 1);
        held_sum = rsp_sum;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== held_sum || req0_ready || req1_ready) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        compare_rsp("hold");
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_to_idle", rsp_valid, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Round-robin with both requesters always valid
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req0_a = 16'h1000; req0_b = 16'h0234; req0_cin = 1'b0;
        req1_a = 16'hABCD; req1_b = 16'h8765; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        ng = 0;
        nr = 0;
        cyc = 0;
        while (nr < 4 && cyc < 60) begin
            if (rsp_valid) begin
                compare_rsp("rr");
                nr++;
            end
            if (req0_ready || req1_ready) begin
                check("rr_one_ready", {req0_ready, req1_ready} != 2'b11, 1);
                if (ng < 4) grants[ng] = req1_ready;
                sb.push_back(req1_ready ? model(1'b1, req1_a, req1_b, req1_cin)
                                        : model(1'b0, req0_a, req0_b, req0_cin));
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_responses", nr, 4);
        check("rr_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        sb.delete();
        repeat (2) @(negedge clk);

        // Reset during ADD, idx = 2
        accept("abort", 1'b0, 16'h2222, 16'h3333, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort_slc_idx2", {slc_a, slc_b}, 8'h23);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dropped = sb.pop_back();
        check("abort_outputs", {rsp_valid, rsp_sum, rsp_cout, rsp_id}, 0);
        check("abort_slc", {slc_a, slc_b, slc_cin}, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("abort_no_rsp", saw_valid, 0);
        accept("post_abort", 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
        wait_rsp("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cla_seq_arbiter.md
CLA_SEQ_ARBITER -- requirements
Module: cla_seq_arbiter

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation accepted this cycle when high together with the matching valid.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W  operands per requester.
REQ-007 req0_cin / req1_cin  input  1  carry-in per requester.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_sum  output  W  sum.
REQ-011 rsp_cout  output  1  final carry-out.
REQ-012 rsp_id  output  1  index of the served requester.
REQ-013 slc_a, slc_b  output  4  nibble operands to the external 4-bit carry-lookahead slice.
REQ-014 slc_cin  output  1  slice carry-in.
REQ-015 slc_s  input  4  slice sum; combinational from slc_a, slc_b, slc_cin within the same cycle.
REQ-016 slc_cout  input  1  slice carry-out, combinational.

Function
REQ-017 FSM states: IDLE, ADD, DONE; reset state is IDLE.
REQ-018 In IDLE, reqX_ready is high only for the granted requester; if neither requester is valid, both ready outputs are low.
REQ-019 Grant rule: if exactly one requester is valid, grant it; if both are valid, grant the one not served last (round-robin).
REQ-020 On acceptance (IDLE, valid and ready both high): latch a, b, cin and the id; set nibble index to 0; go to ADD.
REQ-021 In ADD, slc_a/slc_b = nibble[idx] of the latched operands; slc_cin = latched cin when idx = 0, else the carry register.
REQ-022 Each ADD cycle: store slc_s into rsp_sum nibble[idx]; carry register <= slc_cout; idx <= idx+1.
REQ-023 ADD lasts exactly NIBBLES cycles; after the idx = NIBBLES-1 cycle, rsp_cout <= slc_cout and the FSM enters DONE.
REQ-024 rsp_valid is high only in DONE; it rises NIBBLES+1 cycles after the acceptance cycle.
REQ-025 In DONE, rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready is high; then the FSM goes to IDLE on the next edge.
REQ-026 No new request is accepted in ADD or DONE, so both ready outputs are low there; sustained throughput is one operation per NIBBLES+2 cycles.
REQ-027 In IDLE and DONE, slc_a, slc_b and slc_cin are driven to 0.
REQ-028 The round-robin pointer updates only on acceptance.
REQ-029 Arithmetic is unsigned modulo 2^W; {rsp_cout, rsp_sum} = a + b + cin exactly.
REQ-030 Operand changes after acceptance have no effect on the operation in flight.

Reset
REQ-031 While rst_n is low at a clock edge, the block resets as follows:
- state = IDLE, idx = 0, carry register = 0;
- rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0;
- round-robin pointer set so requester 0 wins the first tie.
REQ-032 Reset asserted in ADD or DONE aborts the operation: no response is produced and the operation is not replayed.
REQ-033 Reset has priority over all other events in the same cycle.

Configuration
REQ-034 Macro CLA_SEQ_OVF_FLAG_EN defined: add output port rsp_ovf (1 bit), two's-complement overflow, computed as (a[W-1] == b[W-1]) && (rsp_sum[W-1] != a[W-1]) on the latched operands.
REQ-035 rsp_ovf is registered with rsp_sum, valid only while rsp_valid is high, and reset to 0.
REQ-036 Macro not defined: no rsp_ovf port, no overflow logic; all other behaviour is identical.

Verification (NIBBLES = 4)
REQ-037 req0: a=0x1234, b=0x4321, cin=0 -> rsp_sum=0x5555, cout=0, id=0; rsp_valid 5 cycles after acceptance.
REQ-038 req1: a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, cout=1; with OVF_EN, ovf=0. Second case: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-039 Both requesters valid continuously after reset -> grants alternate in the order 0, 1, 0, 1; the ready of the loser stays low.
REQ-040 rsp_ready held low 10 cycles in DONE -> rsp_valid and rsp_sum stay stable; no ready is asserted; the FSM returns to IDLE one cycle after rsp_ready rises.
REQ-041 rst_n low for 1 cycle during ADD idx = 2 -> rsp_valid never rises for that operation; all outputs are at reset values; the next request completes correctly.
REQ-042 a=0x0F0F, b=0x00F1, cin=1 -> rsp_sum=0x1001, cout=0; checks carry chaining across nibbles and the cin path.
